// File: rtl/axis_orb_stream.sv
// AXI-Stream ORB tagging shell: FIFO plus registered output stage, 1 beat/clk.
// Optional AXIS_ORB_BYPASS_EN adds a per-beat bypass input that passes tdata untouched.
module axis_orb_stream #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned CNT_W      = 20,
  localparam int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef AXIS_ORB_BYPASS_EN
  input  logic                  bypass,
`endif
  input  logic [NUM_CH*8-1:0]   ch_data,
  input  logic [SEL_W-1:0]      mode_sel,
  input  logic [4*COORD_W-1:0]  match_xy,
  input  logic                  match_valid,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [CNT_W-1:0]      frame_cycles,
  output logic                  frame_done,
  output logic [7:0]            match_drop
);

  localparam int unsigned KEEP_W  = DATA_W / 8;
  localparam int unsigned SLOT_W  = 2 * COORD_W;
  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = DATA_W + KEEP_W + 1 + 8;

  typedef enum logic [1:0] {IDLE, P1, P2} coord_state_t;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               accept, pop, close, tag_pop;
  logic [DATA_W-1:0]  head_data;
  logic [KEEP_W-1:0]  head_keep;
  logic               head_last, head_byp;
  logic [7:0]         head_byte, ch_byte;
  logic [DATA_W-1:0]  out_word;

  coord_state_t       state_q, state_d;
  logic [4*COORD_W-1:0] last_xy;
  logic               match_new, latch_en, drop_inc;
  logic [SLOT_W-1:0]  coord_slot;

  logic [CNT_W-1:0]   cyc_cnt, cnt_incl;
  logic               frame_active, active_now;

  assign s_axis_tready = (fifo_level < LVL_W'(FIFO_DEPTH));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pop           = (fifo_level != '0) & (~m_axis_tvalid | m_axis_tready);
  assign {head_data, head_keep, head_last, head_byte} = mem[rd_ptr];
  assign close         = pop & head_last;
  assign tag_pop       = pop & ~head_last & ~head_byp;

  // Channel byte; an out-of-range select yields zero.
  always_comb begin
    ch_byte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mode_sel == SEL_W'(i)) ch_byte = ch_data[8*i +: 8];
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (accept) mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, ch_byte};
  end

`ifdef AXIS_ORB_BYPASS_EN
  logic byp_mem [FIFO_DEPTH];
  always_ff @(posedge s_axis_aclk) begin
    if (accept) byp_mem[wr_ptr] <= bypass;
  end
  assign head_byp = byp_mem[rd_ptr];
`else
  assign head_byp = 1'b0;
`endif

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame count is inclusive of the current cycle once a frame has started.
  assign active_now = frame_active | accept;
  assign cnt_incl   = (active_now && (cyc_cnt != '1)) ? cyc_cnt + CNT_W'(1) : cyc_cnt;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cyc_cnt      <= '0;
      frame_active <= 1'b0;
      frame_cycles <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= close;
      if (close) begin
        cyc_cnt      <= '0;
        frame_cycles <= cnt_incl;
        frame_active <= accept;
      end else begin
        cyc_cnt      <= cnt_incl;
        frame_active <= active_now;
      end
    end
  end

  assign match_new = match_valid & (match_xy != last_xy);

  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    drop_inc   = 1'b0;
    coord_slot = '0;
    case (state_q)
      IDLE: begin
        if (match_new) begin
          latch_en = 1'b1;
          state_d  = P1;
        end
      end
      P1: begin
        coord_slot = {last_xy[COORD_W-1:0], last_xy[2*COORD_W-1:COORD_W]};
        drop_inc   = match_new;
        if (tag_pop) state_d = P2;
      end
      P2: begin
        coord_slot = {last_xy[3*COORD_W-1:2*COORD_W], last_xy[4*COORD_W-1:3*COORD_W]};
        drop_inc   = match_new;
        if (tag_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q    <= IDLE;
      last_xy    <= '0;
      match_drop <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) last_xy <= match_xy;
      if (drop_inc && (match_drop != 8'hFF)) match_drop <= match_drop + 8'd1;
    end
  end

  // Tagged word: channel byte on top, pass-through middle, slot at the bottom.
  always_comb begin
    out_word                 = head_data;
    out_word[DATA_W-1 -: 8]  = head_byte;
    out_word[SLOT_W-1:0]     = head_last ? SLOT_W'(cnt_incl) : coord_slot;
    if (head_byp) out_word   = head_data;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (pop) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_word;
      m_axis_tkeep  <= head_keep;
      m_axis_tlast  <= head_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_orb_stream.sv
// Scoreboard bench for axis_orb_stream: driver pushes expected beats, monitor pops and compares.
module tb_axis_orb_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [63:0] ch_data = '0;
  logic [2:0]  mode_sel = '0;
  logic [39:0] match_xy = '0;
  logic        match_valid = 1'b0;
  logic [4:0]  fifo_level;
  logic [19:0] frame_cycles;
  logic        frame_done;
  logic [7:0]  match_drop;

  axis_orb_stream dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .ch_data(ch_data), .mode_sel(mode_sel), .match_xy(match_xy), .match_valid(match_valid),
    .fifo_level(fifo_level), .frame_cycles(frame_cycles), .frame_done(frame_done),
    .match_drop(match_drop)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [7:0]  byt;
    int unsigned acc;
  } beat_t;

  beat_t       exp_q[$];
  logic [19:0] coord_q[$];
  logic [39:0] last_xy_m = '0;
  int          drop_m = 0;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          exp_frames = 0;
  bit          fr_started = 0;
  int unsigned fr_start = 0;
  bit          check_lat = 0;
  bit          rand_sink = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Called right after a posedge; returns on the posedge that accepted the beat.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last,
                           input logic [2:0] sel, input logic [63:0] ch);
    int n;
    #1;
    s_tdata = d; s_tkeep = k; s_tlast = last; mode_sel = sel; ch_data = ch; s_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        beat_t b;
        b.data = d; b.keep = k; b.last = last; b.acc = cyc;
        b.byt = ch[int'(sel)*8 +: 8];
        exp_q.push_back(b);
        @(posedge clk);
        break;
      end
      @(posedge clk);
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL accept_timeout actual=stalled required=accept");
        break;
      end
    end
  endtask

  task automatic send_rand(input logic [31:0] d, input logic last);
    send_beat(d, 4'($urandom), last, 3'($urandom), {$urandom, $urandom});
  endtask

  task automatic go_idle();
    #1 s_tvalid = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d left required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  // Reference coordinate behaviour: a pending-slot queue stands in for the match FSM.
  task automatic do_match(input logic [39:0] xy);
    #1 match_xy = xy; match_valid = 1'b1;
    if (xy != last_xy_m) begin
      if (coord_q.size() == 0) begin
        last_xy_m = xy;
        coord_q.push_back({xy[9:0], xy[19:10]});
        coord_q.push_back({xy[29:20], xy[39:30]});
      end else if (drop_m < 255) begin
        drop_m++;
      end
    end
    @(posedge clk);
    #1 match_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_new();
    beat_t       e;
    logic [19:0] slot;
    int unsigned pc;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_beat actual=0x%0h required=none", m_tdata);
      return;
    end
    e  = exp_q.pop_front();
    pc = cyc - 1;
    if (!fr_started) begin
      fr_started = 1;
      fr_start   = e.acc;
    end
    if (e.last) begin
      slot = 20'(pc - fr_start + 1);
      fr_started = 0;
      exp_frames++;
      check("frame_done_on_tlast", 64'(frame_done), 64'd1);
      check("frame_cycles", 64'(frame_cycles), 64'(slot));
    end else if (coord_q.size() != 0) begin
      slot = coord_q.pop_front();
    end else begin
      slot = '0;
    end
    check("tdata", 64'(m_tdata), 64'({e.byt, e.data[23:20], slot}));
    check("tkeep", 64'(m_tkeep), 64'(e.keep));
    check("tlast", 64'(m_tlast), 64'(e.last));
    if (check_lat) check("latency", 64'(cyc - e.acc), 64'd2);
  endtask

  // Monitor: new beats are scored, held beats must not change.
  initial begin
    bit          was_valid;
    bit          hs;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    was_valid = 0; hs = 0; pd = '0; pk = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_valid = 0;
        hs = 0;
      end else begin
        if (frame_done) done_cnt++;
        if (m_tvalid) begin
          if (!was_valid || hs) begin
            check_new();
          end else begin
            check("hold_tdata", 64'(m_tdata), 64'(pd));
            check("hold_tkeep", 64'(m_tkeep), 64'(pk));
            check("hold_tlast", 64'(m_tlast), 64'(pl));
          end
        end
        hs = m_tvalid && m_tready;
        was_valid = m_tvalid;
        pd = m_tdata; pk = m_tkeep; pl = m_tlast;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_sink) m_tready = (($urandom % 4) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d4 [4];
    logic [63:0] ch;
    logic [39:0] xa, xb;
    int          done_before;
    int          n;
    d4[0] = 32'h11223344; d4[1] = 32'h55667788; d4[2] = 32'h99AABBCC; d4[3] = 32'hDDEEFF00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_frame_cycles", 64'(frame_cycles), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_match_drop", 64'(match_drop), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);

    // Fixed channel byte, 2-cycle latency, no bubbles.
    check_lat = 1;
    for (int i = 0; i < 4; i++) begin
      ch = {$urandom, $urandom};
      ch[23:16] = 8'hAB;
      send_beat(d4[i], 4'($urandom), (i == 3), 3'd2, ch);
    end
    go_idle();
    drain();
    check_lat = 0;

    // Coordinate insertion: x1=5 y1=6 x2=7 y2=8.
    do_match({10'd8, 10'd7, 10'd6, 10'd5});
    for (int i = 0; i < 3; i++) send_rand($urandom, 1'b0);
    go_idle();
    drain();
    send_rand($urandom, 1'b1);
    go_idle();
    drain();

    // 100-beat frame with continuous flow.
    done_before = done_cnt;
    check_lat = 1;
    for (int i = 0; i < 100; i++) send_rand($urandom, (i == 99));
    go_idle();
    drain();
    check_lat = 0;
    check("frame100_cycles", 64'(frame_cycles), 64'd101);
    check("frame100_done_pulses", 64'(done_cnt - done_before), 64'd1);

    // Output stall with a continuous source.
    fork
      begin
        for (int i = 0; i < 30; i++) send_rand($urandom, (i == 29));
        go_idle();
      end
      begin
        #1 m_tready = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        check("stall_fifo_level", 64'(fifo_level), 64'd16);
        check("stall_tready", 64'(s_tready), 64'd0);
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();

    // Drop on a distinct match in P1; repeats of the latched value are ignored.
    xa = {10'd100, 10'd200, 10'd300, 10'd400};
    xb = {10'd11, 10'd22, 10'd33, 10'd44};
    do_match(xa);
    do_match(xb);
    do_match(xa);
    check("match_drop_p1", 64'(match_drop), 64'(drop_m));
    for (int i = 0; i < 3; i++) send_rand($urandom, 1'b0);
    go_idle();
    drain();
    do_match(xa);
    check("match_drop_repeat", 64'(match_drop), 64'(drop_m));
    for (int i = 0; i < 3; i++) send_rand($urandom, (i == 2));
    go_idle();
    drain();

    // Randomized bursts, matches and back-pressure.
    rand_sink = 1;
    for (int b = 0; b < 25; b++) begin
      if (($urandom % 2) != 0) xa = 40'({$urandom, $urandom});
      if (($urandom % 2) != 0) do_match(xa);
      if (($urandom % 4) == 0) do_match((($urandom % 2) != 0) ? xa : 40'({$urandom, $urandom}));
      n = 1 + ($urandom % 8);
      for (int j = 0; j < n; j++) begin
        send_rand($urandom, (j == n - 1) && ((($urandom % 2) != 0) || (b == 24)));
        if (($urandom % 3) == 0) begin
          #1 s_tvalid = 1'b0;
          repeat ($urandom % 3) @(posedge clk);
        end
      end
      go_idle();
      drain();
    end
    rand_sink = 0;
    @(posedge clk);
    #1 m_tready = 1'b1;
    @(posedge clk);

    // Reset mid-frame with beats in flight.
    #1 m_tready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) send_rand($urandom, 1'b0);
    go_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_fifo_level", 64'(fifo_level), 64'd0);
    check("midrst_match_drop", 64'(match_drop), 64'd0);
    check("midrst_frame_cycles", 64'(frame_cycles), 64'd0);
    exp_q.delete();
    coord_q.delete();
    last_xy_m = '0;
    drop_m = 0;
    fr_started = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) send_rand($urandom, (i == 2));
    go_idle();
    drain();
    check("post_reset_frame_cycles", 64'(frame_cycles), 64'd4);

    check("frame_done_count", 64'(done_cnt), 64'(exp_frames));
    check("match_drop_final", 64'(match_drop), 64'(drop_m));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_orb_stream.md
Name: axis_orb_stream

Overview:
- Parametrised, full-throughput successor to the ORB AXI-Stream shell; replaces the 4-cycle-per-beat handshake FSM with a FIFO plus registered output stage (1 beat/clk).
- Each accepted beat is tagged with a mode-selected ORB result byte, a two-beat match-coordinate insertion slot, and a per-frame cycle count on the tlast beat.
- Sits between the DMA MM2S stream and S2MM stream; the ORB core drives the ch_data and match ports.

Parameters:
- DATA_W, 32, stream width; DATA_W >= 8 + 2*COORD_W required.
- FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2.
- NUM_CH, 8, number of 8-bit result channels.
- COORD_W, 10, width of one coordinate.
- CNT_W, 20, frame cycle counter width; CNT_W <= 2*COORD_W.

Ports:
- s_axis_aclk  in  1  clock; the only clock.
- s_axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata/tkeep/tlast/tvalid  in  DATA_W/DATA_W/8/1/1  input stream.
- s_axis_tready  out  1  input ready.
- m_axis_tdata/tkeep/tlast/tvalid  out  DATA_W/DATA_W/8/1/1  output stream.
- m_axis_tready  in  1  output ready.
- ch_data  in  NUM_CH*8  result bytes; channel i is bits [8i+7:8i].
- mode_sel  in  clog2(NUM_CH)  channel select.
- match_xy  in  4*COORD_W  {y2,x2,y1,x1}, with x1 in the LSBs.
- match_valid  in  1  one-cycle pulse; match_xy is valid.
- fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- frame_cycles  out  CNT_W  last completed frame's count.
- frame_done  out  1  one-cycle pulse when a tlast beat is popped.
- match_drop  out  8  count of dropped matches; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert): m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0. FIFO empty. fifo_level=0, frame_cycles=0, frame_done=0, match_drop=0. Coordinate FSM=IDLE, cyc_cnt=0, frame_active=0. Reset mid-frame discards all in-flight beats.
- s_axis_tready = (fifo_level < FIFO_DEPTH), combinational from registers.
- On input accept (tvalid & tready), the FIFO stores {tdata, tkeep, tlast, ch byte sampled this cycle}. mode_sel >= NUM_CH selects 0x00.
- Output stage loads from the FIFO head when FIFO is non-empty and (!m_axis_tvalid | m_axis_tready).
- m_axis_tvalid holds until handshake; tdata/tkeep/tlast stay stable while tvalid & !tready.
- Latency: a beat accepted in cycle k is visible on m_axis in cycle k+2 if the pipe is empty. Sustained throughput is 1 beat/clk.
- Output word: [DATA_W-1:DATA_W-8] = channel byte; [DATA_W-9:2*COORD_W] = input bits passed through; [2*COORD_W-1:0] = slot. tkeep and tlast are passed through unchanged.
- Slot on a tlast beat: zero-extended saturated cyc_cnt. This overrides coordinates and does not advance the coordinate FSM.
- Coordinate FSM, IDLE -> P1 -> P2 -> IDLE:
  - IDLE: match_valid with match_xy != the last latched value -> latch, go to P1. An identical match is ignored.
  - P1: the next non-tlast pop carries {x1,y1} (x1 in the upper COORD_W bits), then go to P2.
  - P2: the next non-tlast pop carries {x2,y2}, then go to IDLE.
  - In IDLE the slot is 0.
  - A match_valid (new value) arriving in P1/P2 is dropped and match_drop increments.
  - If match_valid and the P2 pop occur in the same cycle, the new match is dropped.
- Frame counter:
  - frame_active is set by any input accept and cleared when a tlast beat is popped.
  - cyc_cnt increments each clock while frame_active, saturating at 2^CNT_W-1.
  - On a tlast pop: the slot = cyc_cnt, frame_cycles <= cyc_cnt, frame_done = 1 for the next cycle, cyc_cnt <= 0.
  - An accept in the same cycle as a tlast pop keeps frame_active = 1 and starts the next count from 0.
- FIFO full: tready = 0; no data is lost. A simultaneous push and pop while full is not possible, because tready = 0.

Optional Feature:
- AXIS_ORB_BYPASS_EN defined: adds input port bypass (1 bit), sampled per beat at input accept. Bypassed beats output the raw tdata, do not advance the coordinate FSM, and their tlast still closes the frame count (count not inserted).
- Undefined: no port; every beat is tagged.

Test Plan:
- Reset, then 4 beats 0x11223344.. with mode_sel=2, ch byte2=0xAB, m_axis_tready=1 -> 4 outputs with [31:24]=0xAB, bits [23:20] passed through, first output 2 cycles after the first accept, no bubbles.
- match_valid with x1=5,y1=6,x2=7,y2=8 before a 3-beat burst -> low 20 bits = 0x01406, 0x01C08, 0x00000.
- 100-beat frame, tlast on the last beat, continuous flow -> last beat [19:0] = frame_cycles = 101, frame_done pulses once.
- m_axis_tready=0 for 40 cycles with a continuous source -> fifo_level reaches 16, s_axis_tready=0, output held stable; after release all beats arrive in order with none lost.
- Second distinct match during P1 -> match_drop=1, only the first match is emitted; a repeated identical match -> ignored, match_drop unchanged.
- Assert s_axis_aresetn low mid-frame -> m_axis_tvalid=0 immediately, fifo_level=0, the next frame counts from 0.
